shared_ram_arbiter: RTL



---
 rtl/shared_ram_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/shared_ram_arbiter.sv
// Cycle-by-cycle round-robin arbiter for the shared work RAM port, sitting between
// the Z80 CPU bus and the video sprite-copy DMA. RAM has one-cycle registered reads.
module shared_ram_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_wait,
  input  logic [AW-1:0] dma_addr,
  input  logic          dma_en,
  output logic          dma_wait,
  output logic [DW-1:0] dma_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_CPU_WR, OWN_DMA} own_t;

  own_t          r_own_d1;
  own_t          w_own;
  logic          r_last_cpu;
  logic          r_served;
  logic          r_done;
  logic [DW-1:0] r_cpu_din;
  logic [DW-1:0] r_dma_data;
  logic          w_cpu_act;
  logic          w_cpu_req;
  logic          w_cpu_gnt;
  logic          w_dma_gnt;

  // A CPU strobe is one request until it drops; r_served blocks re-granting it.
  assign w_cpu_act = cpu_rd | cpu_wr;
  assign w_cpu_req = w_cpu_act & ~r_served;
  assign w_cpu_gnt = ~reset & w_cpu_req & (~dma_en | ~r_last_cpu);
  assign w_dma_gnt = ~reset & dma_en & ~w_cpu_gnt;

  always_comb begin
    w_own    = OWN_NONE;
    ram_addr = dma_addr;
    ram_we   = 1'b0;
    ram_din  = cpu_dout;
    if (w_cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_wr;
      w_own    = cpu_wr ? OWN_CPU_WR : OWN_CPU_RD;
    end else if (w_dma_gnt) begin
      w_own    = OWN_DMA;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_own_d1   <= OWN_NONE;
      r_last_cpu <= 1'b0;
      r_served   <= 1'b0;
      r_done     <= 1'b0;
      r_cpu_din  <= '0;
      r_dma_data <= '0;
    end else begin
      r_own_d1 <= w_own;
      if (w_cpu_gnt) begin
        r_served   <= 1'b1;
        r_last_cpu <= 1'b1;
      end else if (w_dma_gnt) begin
        r_last_cpu <= 1'b0;
      end
      case (r_own_d1)
        OWN_CPU_RD: begin
          r_cpu_din <= ram_dout;
          r_done    <= 1'b1;
        end
        OWN_CPU_WR: r_done     <= 1'b1;
        OWN_DMA:    r_dma_data <= ram_dout;
        default:    ;
      endcase
      // An abandoned strobe still finishes on the RAM but never reports done.
      if (!w_cpu_act) begin
        r_served <= 1'b0;
        r_done   <= 1'b0;
      end
    end
  end

  assign cpu_din  = r_cpu_din;
  assign dma_data = r_dma_data;
  assign cpu_wait = w_cpu_act & ~r_done;
  assign dma_wait = dma_en & ~w_dma_gnt;

endmodule
